// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS-subset execute datapath
// Holds opcode/funct field values, the 4-bit ALU op enum, and the
// B-operand (alu_src) and writeback-source (regsel) selector enums.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;

    localparam logic [4:0] RS_MFC0  = 5'h00;
    localparam logic [4:0] RS_MTC0  = 5'h04;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_AND  = 4'h0,
        ALU_OR   = 4'h1,
        ALU_XOR  = 4'h2,
        ALU_NOR  = 4'h3,
        ALU_ADD  = 4'h4,
        ALU_SUB  = 4'h5,
        ALU_MULS = 4'h6,
        ALU_MULU = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_SLL  = 4'hA,
        ALU_SRL  = 4'hB,
        ALU_SRA  = 4'hC
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_RT   = 2'd0,
        SRC_SEXT = 2'd1,
        SRC_ZEXT = 2'd2
    } alu_src_e;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_HI   = 2'd1,
        SEL_LO   = 2'd2,
        SEL_GPIO = 2'd3
    } regsel_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU for the execute stage
// Ports: a, b (32) operands; shamt (5) shift amount applied to b; op (alu_op_e);
//        lo (32) main result; hi (32) upper product half; zero = (lo == 0).
// Build option: HILO_MULT_EN adds the 32x32->64 multiplier; without it hi is 0.
import mips_pkg::*;

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_e     op,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        zero
);

`ifdef HILO_MULT_EN
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'h0, a} * {32'h0, b};
`endif

    always_comb begin
        lo = 32'h0;
        hi = 32'h0;
        case (op)
            ALU_AND:  lo = a & b;
            ALU_OR:   lo = a | b;
            ALU_XOR:  lo = a ^ b;
            ALU_NOR:  lo = ~(a | b);
            ALU_ADD:  lo = a + b;
            ALU_SUB:  lo = a - b;
`ifdef HILO_MULT_EN
            ALU_MULS: {hi, lo} = prod_s;
            ALU_MULU: {hi, lo} = prod_u;
`endif
            ALU_SLT:  lo = {31'h0, $signed(a) < $signed(b)};
            ALU_SLTU: lo = {31'h0, a < b};
            ALU_SLL:  lo = b << shamt;
            ALU_SRL:  lo = b >> shamt;
            ALU_SRA:  lo = $unsigned($signed(b) >>> shamt);
            default:  lo = 32'h0;
        endcase
    end

    assign zero = (lo == 32'h0);

endmodule

// File: rtl/mips_exec_datapath.sv
// rtl/mips_exec_datapath.sv - execute/writeback datapath of the two-stage MIPS subset
// Ports: clk; rst (sync, active low); instruction_EX (32, 0 = NOP);
//        gpio_in (32, read by mfc0); gpio_out (32, written by mtc0).
// Build option: HILO_MULT_EN builds mult/multu/mfhi/mflo and the hi/lo registers.
import mips_pkg::*;

module mips_exec_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_EX,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out
);

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = instruction_EX[31:26];
    assign rs    = instruction_EX[25:21];
    assign rt    = instruction_EX[20:16];
    assign rd    = instruction_EX[15:11];
    assign shamt = instruction_EX[10:6];
    assign funct = instruction_EX[5:0];
    assign imm   = instruction_EX[15:0];

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    alu_op_e     alu_op;
    alu_src_e    alu_src;
    regsel_e     regsel;
    logic        hilo_we;
    logic        gpio_we;
    logic        is_lui;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rt;
        alu_op  = ALU_ADD;
        alu_src = SRC_RT;
        regsel  = SEL_ALU;
        hilo_we = 1'b0;
        gpio_we = 1'b0;
        is_lui  = 1'b0;
        case (op)
            OP_RTYPE: begin
                wr_addr = rd;
                case (funct)
                    FN_ADD, FN_ADDU: begin wr_en = 1'b1; alu_op = ALU_ADD;  end
                    FN_SUB, FN_SUBU: begin wr_en = 1'b1; alu_op = ALU_SUB;  end
                    FN_AND:          begin wr_en = 1'b1; alu_op = ALU_AND;  end
                    FN_OR:           begin wr_en = 1'b1; alu_op = ALU_OR;   end
                    FN_XOR:          begin wr_en = 1'b1; alu_op = ALU_XOR;  end
                    FN_NOR:          begin wr_en = 1'b1; alu_op = ALU_NOR;  end
                    FN_SLT:          begin wr_en = 1'b1; alu_op = ALU_SLT;  end
                    FN_SLTU:         begin wr_en = 1'b1; alu_op = ALU_SLTU; end
                    FN_SLL:          begin wr_en = 1'b1; alu_op = ALU_SLL;  end
                    FN_SRL:          begin wr_en = 1'b1; alu_op = ALU_SRL;  end
                    FN_SRA:          begin wr_en = 1'b1; alu_op = ALU_SRA;  end
`ifdef HILO_MULT_EN
                    FN_MULT:         begin hilo_we = 1'b1; alu_op = ALU_MULS; end
                    FN_MULTU:        begin hilo_we = 1'b1; alu_op = ALU_MULU; end
                    FN_MFHI:         begin wr_en = 1'b1; regsel = SEL_HI; end
                    FN_MFLO:         begin wr_en = 1'b1; regsel = SEL_LO; end
`endif
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin wr_en = 1'b1; alu_op = ALU_ADD;  alu_src = SRC_SEXT; end
            OP_SLTI:           begin wr_en = 1'b1; alu_op = ALU_SLT;  alu_src = SRC_SEXT; end
            OP_SLTIU:          begin wr_en = 1'b1; alu_op = ALU_SLTU; alu_src = SRC_SEXT; end
            OP_ANDI:           begin wr_en = 1'b1; alu_op = ALU_AND;  alu_src = SRC_ZEXT; end
            OP_ORI:            begin wr_en = 1'b1; alu_op = ALU_OR;   alu_src = SRC_ZEXT; end
            OP_XORI:           begin wr_en = 1'b1; alu_op = ALU_XOR;  alu_src = SRC_ZEXT; end
            // lui reuses the shifter: zero-extended imm shifted left by 16
            OP_LUI: begin
                wr_en   = 1'b1;
                alu_op  = ALU_SLL;
                alu_src = SRC_ZEXT;
                is_lui  = 1'b1;
            end
            OP_COP0: begin
                if (rs == RS_MTC0) begin
                    gpio_we = 1'b1;
                end else if (rs == RS_MFC0) begin
                    wr_en  = 1'b1;
                    regsel = SEL_GPIO;
                end
            end
            default: ;
        endcase
    end

    // Register file; the writeback register is its only write port.
    logic [31:0] regs [0:31];
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // Bypass lets the instruction right behind a producer read its result.
    always_comb begin
        if (rs == 5'd0)
            rs_val = 32'h0;
        else if (wb_we && wb_addr == rs)
            rs_val = wb_data;
        else
            rs_val = regs[rs];

        if (rt == 5'd0)
            rt_val = 32'h0;
        else if (wb_we && wb_addr == rt)
            rt_val = wb_data;
        else
            rt_val = regs[rt];
    end

    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_lo;
    logic [31:0] alu_hi;
    logic        alu_zero;

    always_comb begin
        case (alu_src)
            SRC_SEXT: alu_b = {{16{imm[15]}}, imm};
            SRC_ZEXT: alu_b = {16'h0, imm};
            default:  alu_b = rt_val;
        endcase
    end

    assign alu_shamt = is_lui ? 5'd16 : shamt;

    alu u_alu (
        .a     (rs_val),
        .b     (alu_b),
        .shamt (alu_shamt),
        .op    (alu_op),
        .lo    (alu_lo),
        .hi    (alu_hi),
        .zero  (alu_zero)
    );

`ifdef HILO_MULT_EN
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else if (hilo_we) begin
            hi_q <= alu_hi;
            lo_q <= alu_lo;
        end
    end
`endif

    always_comb begin
        case (regsel)
`ifdef HILO_MULT_EN
            SEL_HI:   wr_data = hi_q;
            SEL_LO:   wr_data = lo_q;
`endif
            SEL_GPIO: wr_data = gpio_in;
            default:  wr_data = alu_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_we   <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= 32'h0;
        end else begin
            wb_we   <= wr_en;
            wb_addr <= wr_addr;
            wb_data <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'h0;
        end else if (wb_we && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            gpio_out <= 32'h0;
        else if (gpio_we)
            gpio_out <= rt_val;
    end

endmodule

// File: tb/tb_mips_exec_datapath.sv
// tb/tb_mips_exec_datapath.sv - directed vector bench for mips_exec_datapath
module tb_mips_exec_datapath;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_EX;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;

    mips_exec_datapath dut (
        .clk            (clk),
        .rst            (rst),
        .instruction_EX (instruction_EX),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] gin;
        bit          chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] ity(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rty(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] mtc0(input logic [4:0] rt);
        return {6'h10, 5'h04, rt, 16'h0};
    endfunction

    function automatic logic [31:0] mfc0(input logic [4:0] rt);
        return {6'h10, 5'h00, rt, 16'h0};
    endfunction

    function automatic void add(input logic [31:0] instr, input logic [31:0] gin);
        vecs.push_back('{instr, gin, 1'b0, 32'h0, ""});
    endfunction

    function automatic void add_chk(input logic [31:0] instr, input logic [31:0] exp,
                                    input string name);
        vecs.push_back('{instr, 32'h0, 1'b1, exp, name});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: gpio_out=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Drive one instruction for one cycle; returns #1 after the rising edge.
    task automatic step(input logic [31:0] instr, input logic [31:0] gin);
        instruction_EX = instr;
        gpio_in        = gin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // bypass chain
        add(ity(6'h08, 0, 1, 16'd5), 0);
        add(ity(6'h08, 1, 2, 16'hFFF9), 0);
        add_chk(mtc0(2), 32'hFFFFFFFE, "addi_bypass_mtc0");
        // ori / lui / or
        add(ity(6'h0D, 0, 3, 16'hFFFF), 0);
        add(ity(6'h0F, 0, 4, 16'h1234), 0);
        add(rty(4, 3, 5, 0, 6'h25), 0);
        add_chk(mtc0(5), 32'h1234FFFF, "ori_lui_or");
        // signed vs unsigned compare, shifts
        add(ity(6'h08, 0, 6, 16'hFFFF), 0);
        add(ity(6'h08, 0, 7, 16'd1), 0);
        add(rty(6, 7, 9, 0, 6'h2A), 0);
        add_chk(mtc0(9), 32'h00000001, "slt");
        add(rty(6, 7, 10, 0, 6'h2B), 0);
        add_chk(mtc0(10), 32'h00000000, "sltu");
        add(ity(6'h0F, 0, 11, 16'h8000), 0);
        add(rty(0, 11, 12, 5'd4, 6'h03), 0);
        add_chk(mtc0(12), 32'hF8000000, "sra");
        add(rty(0, 11, 13, 5'd4, 6'h02), 0);
        add_chk(mtc0(13), 32'h08000000, "srl");
        add(rty(0, 7, 14, 5'd31, 6'h00), 0);
        add_chk(mtc0(14), 32'h80000000, "sll31");
        add(rty(5, 3, 15, 0, 6'h22), 0);
        add_chk(mtc0(15), 32'h12340000, "sub");
        add(rty(0, 3, 16, 0, 6'h27), 0);
        add_chk(mtc0(16), 32'hFFFF0000, "nor");
        add(ity(6'h0E, 5, 17, 16'hFFFF), 0);
        add_chk(mtc0(17), 32'h12340000, "xori");
        add(ity(6'h0C, 6, 18, 16'h8001), 0);
        add_chk(mtc0(18), 32'h00008001, "andi_zext");
        add(ity(6'h0A, 6, 19, 16'h0000), 0);
        add_chk(mtc0(19), 32'h00000001, "slti_neg");
        add(ity(6'h0B, 6, 19, 16'h0001), 0);
        add_chk(mtc0(19), 32'h00000000, "sltiu");
        add(ity(6'h0B, 7, 20, 16'hFFFF), 0);
        add_chk(mtc0(20), 32'h00000001, "sltiu_sext");
        // GPIO input path; the mtc0 runs with gpio_in changed
        add(mfc0(8), 32'hA5A5A5A5);
        add_chk(mtc0(8), 32'hA5A5A5A5, "mfc0_mtc0");
        // $0 stays zero
        add(ity(6'h08, 0, 0, 16'd7), 0);
        add_chk(mtc0(0), 32'h00000000, "r0_addi");
        add(mtc0(7), 0);
        add(rty(5, 5, 0, 0, 6'h25), 0);
        add_chk(mtc0(0), 32'h00000000, "r0_or");
        // undefined opcode (lw) and 0 are NOPs
        add(ity(6'h23, 0, 1, 16'h0000), 0);
        add(32'h0, 0);
        add_chk(mtc0(1), 32'h00000005, "nop_encoding");
        add(rty(6, 7, 25, 0, 6'h21), 0);
        add_chk(mtc0(25), 32'h00000000, "addu_wrap");
`ifdef HILO_MULT_EN
        add(ity(6'h08, 0, 22, 16'hFFFF), 0);
        add(ity(6'h08, 0, 23, 16'd2), 0);
        add(rty(22, 23, 0, 0, 6'h18), 0);
        add(rty(0, 0, 24, 0, 6'h10), 0);
        add_chk(mtc0(24), 32'hFFFFFFFF, "mult_hi");
        add(rty(0, 0, 24, 0, 6'h12), 0);
        add_chk(mtc0(24), 32'hFFFFFFFE, "mult_lo");
        add(rty(22, 23, 0, 0, 6'h19), 0);
        add(rty(0, 0, 24, 0, 6'h10), 0);
        add_chk(mtc0(24), 32'h00000001, "multu_hi");
        add(rty(0, 0, 24, 0, 6'h12), 0);
        add_chk(mtc0(24), 32'hFFFFFFFE, "multu_lo");
`else
        // hi/lo instructions must not touch the register file
        add(ity(6'h08, 0, 21, 16'h0077), 0);
        add(rty(6, 7, 0, 0, 6'h18), 0);
        add(rty(0, 0, 21, 0, 6'h10), 0);
        add(rty(0, 0, 21, 0, 6'h12), 0);
        add_chk(mtc0(21), 32'h00000077, "hilo_absent_nop");
`endif

        rst            = 1'b0;
        instruction_EX = 32'h0;
        gpio_in        = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gpio_out", gpio_out, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].instr, vecs[i].gin);
            if (vecs[i].chk)
                check(vecs[i].name, gpio_out, vecs[i].exp);
        end

        // Reset lands while an addi is sitting in writeback.
        step(mtc0(7), 0);
        check("pre_reset_gpio", gpio_out, 32'h00000001);
        step(ity(6'h08, 0, 26, 16'd9), 0);
        rst = 1'b0;
        step(32'h0, 0);
        check("reset_clears_gpio", gpio_out, 32'h0);
        rst = 1'b1;
        step(mtc0(26), 0);
        check("reset_drops_wb", gpio_out, 32'h0);
        step(mtc0(7), 0);
        check("reset_clears_regs", gpio_out, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
